// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - two-entry in-order retirement buffer behind the 16-bit ALU
// Retires each entry as a register write, a CPSR update, or a sticky divide trap.
module alu_writeback_stage #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [AW-1:0]    in_dest,
  input  logic [WIDTH-1:0] in_r,
  input  logic [3:0]       in_flags,
  input  logic             in_div_inv,
  output logic             wr_en,
  input  logic             wr_ready,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic [3:0]       cpsr,
  output logic             div_trap,
  input  logic             trap_clr,
  output logic             illegal_op,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {CLS_WRITE, CLS_COMPARE, CLS_ILLEGAL, CLS_DIVFAULT} cls_e;
  typedef enum logic {ST_RUN, ST_TRAP} state_e;

  cls_e             cls_q   [2];
  logic [AW-1:0]    dest_q  [2];
  logic [WIDTH-1:0] data_q  [2];
  logic [3:0]       flags_q [2];

  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q, count_d;
  state_e     state_q;
  logic [3:0] cpsr_q;
  logic       div_trap_q;
  logic       illegal_q;
  logic [15:0] op_count_q;

  cls_e in_cls;
  cls_e head_cls;
  logic push, retire, has_head, running, updates_cpsr;

  // Class is decoded once at accept so retirement only looks at two stored bits.
  always_comb begin
    in_cls = CLS_WRITE;
    case (in_opcode)
      5'b00101, 5'b10101, 5'b11110:           in_cls = CLS_COMPARE;
      5'b10100, 5'b10111, 5'b11101, 5'b11111: in_cls = CLS_ILLEGAL;
      5'b01101: if (in_div_inv)               in_cls = CLS_DIVFAULT;
      default: ;
    endcase
  end

  assign head_cls     = cls_q[rd_ptr_q];
  assign has_head     = (count_q != 2'd0);
  assign running      = (state_q == ST_RUN);
  assign in_ready     = (count_q != 2'd2);
  assign push         = in_valid && in_ready;
  assign retire       = running && has_head && ((head_cls != CLS_WRITE) || wr_ready);
  assign updates_cpsr = (head_cls == CLS_WRITE) || (head_cls == CLS_COMPARE);

  assign wr_en      = running && has_head && (head_cls == CLS_WRITE);
  assign wr_addr    = dest_q[rd_ptr_q];
  assign wr_data    = data_q[rd_ptr_q];
  assign cpsr       = cpsr_q;
  assign div_trap   = div_trap_q;
  assign illegal_op = illegal_q;
  assign op_count   = op_count_q;

  always_comb begin
    count_d = count_q;
    case ({push, retire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cls_q[wr_ptr_q]   <= in_cls;
      dest_q[wr_ptr_q]  <= in_dest;
      data_q[wr_ptr_q]  <= in_r;
      flags_q[wr_ptr_q] <= in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push)   wr_ptr_q <= ~wr_ptr_q;
      if (retire) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // trap_clr is only honoured in TRAP, so a clear coinciding with a fault retire is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      div_trap_q <= 1'b0;
      illegal_q  <= 1'b0;
      cpsr_q     <= 4'b0000;
      op_count_q <= 16'h0000;
    end else begin
      illegal_q <= retire && (head_cls == CLS_ILLEGAL);
      case (state_q)
        ST_RUN: begin
          if (retire && (head_cls == CLS_DIVFAULT)) begin
            state_q    <= ST_TRAP;
            div_trap_q <= 1'b1;
          end
        end
        ST_TRAP: begin
          if (trap_clr) begin
            state_q    <= ST_RUN;
            div_trap_q <= 1'b0;
          end
        end
        default: state_q <= ST_RUN;
      endcase
      if (retire && updates_cpsr) begin
        cpsr_q     <= flags_q[rd_ptr_q];
        op_count_q <= op_count_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - directed and randomized checks of alu_writeback_stage
// against a queue-based reference model.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic [3:0]  in_dest = '0;
  logic [15:0] in_r = '0;
  logic [3:0]  in_flags = '0;
  logic        in_div_inv = 1'b0;
  logic        wr_en;
  logic        wr_ready = 1'b0;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  cpsr;
  logic        div_trap;
  logic        trap_clr = 1'b0;
  logic        illegal_op;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;

  alu_writeback_stage #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dest(in_dest), .in_r(in_r), .in_flags(in_flags), .in_div_inv(in_div_inv),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpsr(cpsr), .div_trap(div_trap), .trap_clr(trap_clr),
    .illegal_op(illegal_op), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  dest;
    logic [15:0] r;
    logic [3:0]  fl;
    logic        dv;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_cpsr;
  logic        m_trap;
  logic        m_ill;
  logic [15:0] m_cnt;

  // 0 = write, 1 = compare, 2 = illegal, 3 = divide fault
  function automatic int cls_of(logic [4:0] op, logic dv);
    if (op == 5'b00101 || op == 5'b10101 || op == 5'b11110) return 1;
    if (op == 5'b10100 || op == 5'b10111 || op == 5'b11101 || op == 5'b11111) return 2;
    if (op == 5'b01101 && dv) return 3;
    return 0;
  endfunction

  function automatic logic exp_wr_en();
    if (m_trap || mq.size() == 0) return 1'b0;
    return cls_of(mq[0].op, mq[0].dv) == 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cpsr = 4'b0000;
    m_trap = 1'b0;
    m_ill  = 1'b0;
    m_cnt  = 16'h0000;
  endtask

  task automatic model_edge();
    ent_t e;
    logic acc;
    logic ill_n;
    acc   = in_valid && (mq.size() != 2);
    ill_n = 1'b0;
    if (!m_trap && mq.size() != 0) begin
      case (cls_of(mq[0].op, mq[0].dv))
        0: if (wr_ready) begin m_cpsr = mq[0].fl; m_cnt = m_cnt + 16'd1; void'(mq.pop_front()); end
        1: begin m_cpsr = mq[0].fl; m_cnt = m_cnt + 16'd1; void'(mq.pop_front()); end
        2: begin ill_n = 1'b1; void'(mq.pop_front()); end
        default: begin m_trap = 1'b1; void'(mq.pop_front()); end
      endcase
    end else if (m_trap && trap_clr) begin
      m_trap = 1'b0;
    end
    m_ill = ill_n;
    if (acc) begin
      e.op = in_opcode; e.dest = in_dest; e.r = in_r; e.fl = in_flags; e.dv = in_div_inv;
      mq.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic present(logic v, logic [4:0] op, logic [3:0] d, logic [15:0] r, logic [3:0] fl, logic dv);
    in_valid = v; in_opcode = op; in_dest = d; in_r = r; in_flags = fl; in_div_inv = dv;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    wr_ready = 1'b0;
    trap_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (cpsr !== 4'b0000) begin bad++; $display("FAIL reset_cpsr got=%b exp=0000", cpsr); end
    total++; if (div_trap !== 1'b0) begin bad++; $display("FAIL reset_div_trap got=%b exp=0", div_trap); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal_op); end
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
  endtask

  task automatic test_add();
    do_reset();
    wr_ready = 1'b1;
    present(1'b1, 5'b00001, 4'd3, 16'h1234, 4'b0000, 1'b0);
    cyc();
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL add_wr_en got=%b exp=1", wr_en); end
    total++; if (wr_addr !== 4'd3) begin bad++; $display("FAIL add_wr_addr got=%h exp=3", wr_addr); end
    total++; if (wr_data !== 16'h1234) begin bad++; $display("FAIL add_wr_data got=%h exp=1234", wr_data); end
    cyc();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL add_wr_en_after got=%b exp=0", wr_en); end
    total++; if (cpsr !== 4'b0000) begin bad++; $display("FAIL add_cpsr got=%b exp=0000", cpsr); end
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL add_op_count got=%h exp=0001", op_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_ready = 1'b0;
    present(1'b1, 5'b00001, 4'd1, 16'hAAA1, 4'b0001, 1'b0);
    cyc();
    present(1'b1, 5'b00010, 4'd2, 16'hBBB2, 4'b0010, 1'b0);
    cyc();
    present(1'b1, 5'b00011, 4'd3, 16'hCCC3, 4'b0011, 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (wr_en !== 1'b1 || wr_addr !== 4'd1 || wr_data !== 16'hAAA1) begin
        bad++; $display("FAIL b2b_stall_hold got=%b/%h/%h exp=1/1/aaa1", wr_en, wr_addr, wr_data);
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready got=%b exp=0", in_ready); end
    end
    wr_ready = 1'b1;
    cyc();
    total++; if (wr_addr !== 4'd2 || wr_data !== 16'hBBB2 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_second got=%h/%h/%b exp=2/bbb2/1", wr_addr, wr_data, in_ready);
    end
    cyc();
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    total++; if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 16'hCCC3) begin
      bad++; $display("FAIL b2b_third got=%b/%h/%h exp=1/3/ccc3", wr_en, wr_addr, wr_data);
    end
    cyc();
    total++; if (op_count !== 16'd3 || cpsr !== 4'b0011 || wr_en !== 1'b0) begin
      bad++; $display("FAIL b2b_done got=%h/%b/%b exp=0003/0011/0", op_count, cpsr, wr_en);
    end
  endtask

  task automatic test_compare();
    do_reset();
    wr_ready = 1'b1;
    present(1'b1, 5'b00101, 4'd9, 16'h5555, 4'b0100, 1'b0);
    cyc();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL cmp_no_write got=%b exp=0", wr_en); end
    present(1'b1, 5'b00100, 4'd2, 16'h0F0F, 4'b1000, 1'b0);
    cyc();
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    total++; if (cpsr !== 4'b0100) begin bad++; $display("FAIL cmp_cpsr1 got=%b exp=0100", cpsr); end
    total++; if (wr_en !== 1'b1 || wr_addr !== 4'd2) begin bad++; $display("FAIL cmp_then_write got=%b/%h exp=1/2", wr_en, wr_addr); end
    cyc();
    total++; if (cpsr !== 4'b1000) begin bad++; $display("FAIL cmp_cpsr2 got=%b exp=1000", cpsr); end
    total++; if (op_count !== 16'd2) begin bad++; $display("FAIL cmp_op_count got=%h exp=0002", op_count); end
  endtask

  task automatic test_trap();
    do_reset();
    wr_ready = 1'b1;
    present(1'b1, 5'b01101, 4'd4, 16'hDEAD, 4'b1111, 1'b1);
    cyc();
    present(1'b1, 5'b00001, 4'd5, 16'h00C5, 4'b0010, 1'b0);
    trap_clr = 1'b1;
    cyc();
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    trap_clr = 1'b0;
    total++; if (div_trap !== 1'b1) begin bad++; $display("FAIL trap_set got=%b exp=1", div_trap); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (wr_en !== 1'b0 || div_trap !== 1'b1 || cpsr !== 4'b0000) begin
        bad++; $display("FAIL trap_hold got=%b/%b/%b exp=0/1/0000", wr_en, div_trap, cpsr);
      end
    end
    trap_clr = 1'b1;
    cyc();
    trap_clr = 1'b0;
    total++; if (div_trap !== 1'b0) begin bad++; $display("FAIL trap_clear got=%b exp=0", div_trap); end
    total++; if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 16'h00C5) begin
      bad++; $display("FAIL trap_resume got=%b/%h/%h exp=1/5/00c5", wr_en, wr_addr, wr_data);
    end
    cyc();
    total++; if (op_count !== 16'd1 || cpsr !== 4'b0010) begin
      bad++; $display("FAIL trap_count got=%h/%b exp=0001/0010", op_count, cpsr);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    wr_ready = 1'b1;
    present(1'b1, 5'b11110, 4'd0, 16'h0000, 4'b0011, 1'b0);
    cyc();
    present(1'b1, 5'b11111, 4'd6, 16'h6666, 4'b1100, 1'b0);
    cyc();
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_early got=%b exp=0", illegal_op); end
    cyc();
    total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%b exp=1", illegal_op); end
    total++; if (cpsr !== 4'b0011 || op_count !== 16'd1 || wr_en !== 1'b0) begin
      bad++; $display("FAIL ill_side got=%b/%h/%b exp=0011/0001/0", cpsr, op_count, wr_en);
    end
    cyc();
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_width got=%b exp=0", illegal_op); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      present($urandom_range(0, 3) != 0, 5'($urandom), 4'($urandom), 16'($urandom),
              4'($urandom), $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) in_opcode = 5'b01101;
      wr_ready = $urandom_range(0, 2) != 0;
      trap_clr = m_trap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      cyc();
      total++; if (in_ready !== (mq.size() != 2)) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, in_ready, mq.size() != 2); end
      total++; if (wr_en !== exp_wr_en()) begin bad++; $display("FAIL rnd_wr_en n=%0d got=%b exp=%b", n, wr_en, exp_wr_en()); end
      if (exp_wr_en()) begin
        total++; if (wr_addr !== mq[0].dest || wr_data !== mq[0].r) begin
          bad++; $display("FAIL rnd_wr_payload n=%0d got=%h/%h exp=%h/%h", n, wr_addr, wr_data, mq[0].dest, mq[0].r);
        end
      end
      total++; if (cpsr !== m_cpsr) begin bad++; $display("FAIL rnd_cpsr n=%0d got=%b exp=%b", n, cpsr, m_cpsr); end
      total++; if (div_trap !== m_trap) begin bad++; $display("FAIL rnd_div_trap n=%0d got=%b exp=%b", n, div_trap, m_trap); end
      total++; if (illegal_op !== m_ill) begin bad++; $display("FAIL rnd_illegal n=%0d got=%b exp=%b", n, illegal_op, m_ill); end
      total++; if (op_count !== m_cnt) begin bad++; $display("FAIL rnd_op_count n=%0d got=%h exp=%h", n, op_count, m_cnt); end
    end
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    trap_clr = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset();
    int guard;
    do_reset();
    wr_ready = 1'b1;
    present(1'b1, 5'b10101, 4'd0, 16'h0000, 4'b1010, 1'b0);
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cyc();
      guard++;
    end
    total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff guard=%0d", op_count, guard); end
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    cyc();
    total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL wrap_rollover got=%h exp=0000", op_count); end
    wr_ready = 1'b0;
    present(1'b1, 5'b00001, 4'd7, 16'h7777, 4'b0101, 1'b0);
    cyc();
    cyc();
    present(1'b0, 5'd0, 4'd0, 16'd0, 4'd0, 1'b0);
    total++; if (wr_en !== 1'b1 || in_ready !== 1'b0 || cpsr !== 4'b1010) begin
      bad++; $display("FAIL stall_before_reset got=%b/%b/%b exp=1/0/1010", wr_en, in_ready, cpsr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (wr_en !== 1'b0 || cpsr !== 4'b0000 || in_ready !== 1'b1 || op_count !== 16'h0000) begin
      bad++; $display("FAIL async_reset got=%b/%b/%b/%h exp=0/0000/1/0000", wr_en, cpsr, in_ready, op_count);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    cyc();
    total++; if (wr_en !== 1'b0 || op_count !== 16'h0000) begin
      bad++; $display("FAIL reset_discards got=%b/%h exp=0/0000", wr_en, op_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_compare();
    test_trap();
    test_illegal();
    test_random();
    test_wrap_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
